// File: rtl/axi4lite_if.sv
// AXI4-Lite slave bridging single-beat reads/writes onto a simple strobed IP register port.
// One transaction in flight; writes take priority over reads when both are requested in IDLE.
module axi4lite_if #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int IP_DATA_WIDTH = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [2:0]                awprot,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [1:0]                bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic [2:0]                arprot,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [1:0]                rresp,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      ip_en,
  output logic                      ip_wen,
  output logic [ADDR_WIDTH-1:0]     ip_addr,
  output logic [IP_DATA_WIDTH-1:0]  ip_wdata,
  input  logic                      ip_rack,
  input  logic [IP_DATA_WIDTH-1:0]  ip_rdata
);

  typedef enum logic [2:0] {IDLE, WR_IP, WR_RESP, RD_IP, RD_WAIT, RD_RESP} state_t;

  state_t state;
  logic   wr_go;
  logic   rd_go;
  logic   unused;

  // Ready gating includes aresetn so the handshake outputs read 0 throughout reset.
  always_comb begin
    wr_go = 1'b0;
    rd_go = 1'b0;
    if (aresetn && state == IDLE) begin
      wr_go = awvalid && wvalid;
      rd_go = arvalid && !(awvalid && wvalid);
    end
  end

  assign awready = wr_go;
  assign wready  = wr_go;
  assign arready = rd_go;
  assign bresp   = 2'b00;
  assign rresp   = 2'b00;
  assign unused  = ^{awprot, arprot, wstrb, wdata, awaddr[1:0], araddr[1:0]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      bvalid   <= 1'b0;
      rvalid   <= 1'b0;
      ip_en    <= 1'b0;
      ip_wen   <= 1'b0;
      rdata    <= '0;
      ip_addr  <= '0;
      ip_wdata <= '0;
    end else begin
      ip_en  <= 1'b0;
      ip_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_go) begin
            ip_addr  <= {2'b00, awaddr[ADDR_WIDTH-1:2]};
            ip_wdata <= wdata[IP_DATA_WIDTH-1:0];
            ip_en    <= 1'b1;
            ip_wen   <= 1'b1;
            state    <= WR_IP;
          end else if (rd_go) begin
            ip_addr <= {2'b00, araddr[ADDR_WIDTH-1:2]};
            ip_en   <= 1'b1;
            state   <= RD_IP;
          end
        end
        WR_IP: begin
          bvalid <= 1'b1;
          state  <= WR_RESP;
        end
        WR_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        RD_IP: state <= RD_WAIT;
        RD_WAIT: begin
          if (ip_rack) begin
            rdata  <= DATA_WIDTH'(ip_rdata);
            rvalid <= 1'b1;
            state  <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_if.sv
// Bench for axi4lite_if: acts as AXI master and as the IP register block, checking
// against a word-addressed shadow memory built from AXI-side transaction values.
module tb_axi4lite_if;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int IW = 8;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          awvalid, wvalid, bready, arvalid, rready, ip_rack;
  logic          awready, wready, bvalid, arready, rvalid, ip_en, ip_wen;
  logic [AW-1:0] awaddr, araddr, ip_addr;
  logic [2:0]    awprot, arprot;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [IW-1:0] ip_wdata, ip_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] ip_mem [64];
  logic [7:0] shadow [64];
  logic [7:0] last_addr;
  logic [7:0] last_wdata;

  always #5 aclk = ~aclk;

  axi4lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IP_DATA_WIDTH(IW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata),
    .ip_en(ip_en), .ip_wen(ip_wen), .ip_addr(ip_addr), .ip_wdata(ip_wdata),
    .ip_rack(ip_rack), .ip_rdata(ip_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_ip_en", ip_en, 0);
    check("rst_ip_wen", ip_wen, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ip_addr", ip_addr, 0);
    check("rst_ip_wdata", ip_wdata, 0);
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic write_txn(input logic [7:0] addr, input logic [31:0] data, input int bwait);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = addr; wdata = data;
    awprot = 3'($urandom); wstrb = 4'($urandom);
    #1;
    check("wr_awready", awready, 1);
    check("wr_wready", wready, 1);
    check("wr_arready", arready, 0);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; awaddr = 8'($urandom); wdata = $urandom;
    #1;
    check("wr_ip_en", ip_en, 1);
    check("wr_ip_wen", ip_wen, 1);
    check("wr_ip_addr", ip_addr, {2'b00, addr[7:2]});
    check("wr_ip_wdata", ip_wdata, data[7:0]);
    check("wr_bvalid_early", bvalid, 0);
    check("wr_awready_busy", awready, 0);
    if (ip_en && ip_wen) ip_mem[ip_addr[5:0]] = ip_wdata;
    shadow[addr[7:2]] = data[7:0];
    last_addr = {2'b00, addr[7:2]};
    last_wdata = data[7:0];
    @(negedge aclk); #1;
    check("wr_ip_en_off", ip_en, 0);
    check("wr_ip_wen_off", ip_wen, 0);
    check("wr_bvalid", bvalid, 1);
    check("wr_bresp", bresp, 0);
    repeat (bwait) begin
      @(negedge aclk); #1;
      check("wr_bvalid_hold", bvalid, 1);
      check("wr_arready_hold", arready, 0);
      check("wr_ip_en_hold", ip_en, 0);
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    #1;
    check("wr_bvalid_done", bvalid, 0);
  endtask

  task automatic read_txn(input logic [7:0] addr, input int rdelay, input int rwait, input bit spurious);
    logic [5:0]  a;
    logic [31:0] exp;
    exp = {24'h0, shadow[addr[7:2]]};
    arvalid = 1'b1; araddr = addr; arprot = 3'($urandom);
    #1;
    check("rd_arready", arready, 1);
    check("rd_awready", awready, 0);
    @(negedge aclk);
    arvalid = 1'b0; araddr = 8'($urandom);
    #1;
    check("rd_ip_en", ip_en, 1);
    check("rd_ip_wen", ip_wen, 0);
    check("rd_ip_addr", ip_addr, {2'b00, addr[7:2]});
    check("rd_rvalid_early", rvalid, 0);
    a = ip_addr[5:0];
    last_addr = {2'b00, addr[7:2]};
    if (spurious) begin
      ip_rack = 1'b1;
      ip_rdata = 8'($urandom);
    end
    for (int i = 1; i < rdelay; i++) begin
      @(negedge aclk);
      ip_rack = 1'b0;
      #1;
      check("rd_ip_en_wait", ip_en, 0);
      check("rd_rvalid_wait", rvalid, 0);
    end
    @(negedge aclk);
    ip_rack = 1'b1;
    ip_rdata = ip_mem[a];
    @(negedge aclk);
    ip_rack = 1'b0;
    ip_rdata = 8'($urandom);
    #1;
    check("rd_rvalid", rvalid, 1);
    check("rd_rdata", rdata, exp);
    check("rd_rresp", rresp, 0);
    repeat (rwait) begin
      @(negedge aclk);
      ip_rdata = 8'($urandom);
      #1;
      check("rd_rvalid_hold", rvalid, 1);
      check("rd_rdata_hold", rdata, exp);
      check("rd_arready_hold", arready, 0);
    end
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    #1;
    check("rd_rvalid_done", rvalid, 0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge aclk); #1;
      check("idle_ip_en", ip_en, 0);
      check("idle_ip_addr_hold", ip_addr, last_addr);
      check("idle_ip_wdata_hold", ip_wdata, last_wdata);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      ip_mem[i] = 8'($urandom);
      shadow[i] = ip_mem[i];
    end
    aresetn = 1'b0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; ip_rack = 0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0; ip_rdata = '0;
    @(negedge aclk);
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    #1;
    check_reset_values();
    @(negedge aclk);
    arvalid = 1'b0;
    aresetn = 1'b1;

    // Handshake on the first rising edge after reset release; word address 0x05, low byte kept
    write_txn(8'h14, 32'h1234_56A5, 0);
    // Unaligned address aliases to the same word
    write_txn(8'h15, 32'hFFFF_FFC3, 0);
    read_txn(8'h16, 3, 0, 1'b0);
    idle_cycles(2);

    // Backpressure on both response channels
    write_txn(8'h40, 32'h0000_0077, 4);
    read_txn(8'h41, 2, 4, 1'b1);

    // Simultaneous write and read: write first, read accepted right after bready
    arvalid = 1'b1; araddr = 8'h40;
    write_txn(8'h80, 32'hDEAD_BE11, 2);
    read_txn(8'h40, 1, 1, 1'b0);

    // Lone AW and lone W must not be accepted
    awvalid = 1'b1; awaddr = 8'h24; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("lone_aw_awready", awready, 0);
      check("lone_aw_wready", wready, 0);
      check("lone_aw_ip_en", ip_en, 0);
      @(negedge aclk);
    end
    awvalid = 1'b0; wvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("lone_w_wready", wready, 0);
      check("lone_w_ip_en", ip_en, 0);
      @(negedge aclk);
    end
    write_txn(8'h24, 32'h0000_0099, 0);

    // Reset during RD_WAIT aborts the read; a later ip_rack is ignored
    arvalid = 1'b1; araddr = 8'h20;
    @(negedge aclk);
    arvalid = 1'b0;
    @(negedge aclk);
    #2;
    aresetn = 1'b0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    #1;
    check_reset_values();
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    aresetn = 1'b1;
    ip_rack = 1'b1; ip_rdata = 8'h5A;
    @(negedge aclk);
    ip_rack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("abort_rvalid", rvalid, 0);
      check("abort_rdata", rdata, 0);
      check("abort_ip_en", ip_en, 0);
      @(negedge aclk);
    end
    last_addr = '0;
    last_wdata = '0;

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0)
        write_txn(8'($urandom), $urandom, int'($urandom_range(0, 3)));
      else
        read_txn(8'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4lite_if.md
AXI4LITE_IF -- requirements
Module: axi4lite_if

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: AXI byte-address width and ip_addr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: AXI data width; only 32 supported.
REQ-003 SHALL have parameter IP_DATA_WIDTH, default 16: IP-side data width, 1..DATA_WIDTH.
REQ-004 SHALL have ports `aclk` (in, 1, sole clock) and `aresetn` (in, 1); one clock; reset is asynchronous and active-low.
REQ-005 SHALL have write-address ports `awvalid` (in, 1), `awready` (out, 1), `awaddr` (in, ADDR_WIDTH) and `awprot` (in, 3, ignored).
REQ-006 SHALL have write-data ports `wvalid` (in, 1), `wready` (out, 1), `wdata` (in, DATA_WIDTH) and `wstrb` (in, DATA_WIDTH/8, ignored).
REQ-007 SHALL have write-response ports `bvalid` (out, 1), `bready` (in, 1) and `bresp` (out, 2).
REQ-008 SHALL have read-address ports `arvalid` (in, 1), `arready` (out, 1), `araddr` (in, ADDR_WIDTH) and `arprot` (in, 3, ignored).
REQ-009 SHALL have read-data ports `rvalid` (out, 1), `rready` (in, 1), `rresp` (out, 2) and `rdata` (out, DATA_WIDTH).
REQ-010 SHALL have IP-side ports `ip_en` (out, 1, access strobe), `ip_wen` (out, 1, 1=write), `ip_addr` (out, ADDR_WIDTH, word address), `ip_wdata` (out, IP_DATA_WIDTH), `ip_rack` (in, 1, read-data valid pulse) and `ip_rdata` (in, IP_DATA_WIDTH).

Function
REQ-011 SHALL use FSM states IDLE, WR_IP, WR_RESP, RD_IP, RD_WAIT, RD_RESP, with exactly one transaction in flight.
REQ-012 In IDLE, SHALL drive awready=wready=1 combinationally iff awvalid&&wvalid; all other states hold them 0.
REQ-013 In IDLE, SHALL drive arready=1 iff arvalid && !(awvalid&&wvalid): write wins on simultaneous requests, and the read stays pending.
REQ-014 SHALL never accept AW without W in the same cycle; a lone AW or lone W waits with ready=0.
REQ-015 On write handshake, SHALL latch ip_addr = {2'b00, awaddr[ADDR_WIDTH-1:2]} and ip_wdata = wdata[IP_DATA_WIDTH-1:0], then go to WR_IP.
REQ-016 In WR_IP, SHALL drive ip_en=1 and ip_wen=1 for exactly one cycle, then go to WR_RESP.
REQ-017 In WR_RESP, SHALL hold bvalid=1 and bresp=2'b00 until bready, then return to IDLE; the next handshake is possible in the following cycle.
REQ-018 On read handshake, SHALL latch ip_addr = {2'b00, araddr[ADDR_WIDTH-1:2]} and go to RD_IP.
REQ-019 In RD_IP, SHALL drive ip_en=1 and ip_wen=0 for one cycle, then go to RD_WAIT.
REQ-020 ip_rack SHALL be ignored except in RD_WAIT; no timeout.
REQ-021 In RD_WAIT, on ip_rack=1 SHALL register rdata = zero-extended ip_rdata, and rresp=2'b00, and go to RD_RESP.
REQ-022 In RD_RESP, SHALL hold rvalid=1 and rdata stable until rready, then return to IDLE.
REQ-023 Outside WR_IP/RD_IP, SHALL hold ip_en=0 and ip_wen=0.
REQ-024 ip_addr and ip_wdata SHALL hold their last latched values between transactions.
REQ-025 Address bits [1:0] SHALL be discarded, so unaligned addresses alias to the containing word.
REQ-026 wdata bits above IP_DATA_WIDTH SHALL be dropped.
REQ-027 bresp/rresp SHALL always be OKAY (2'b00); no error responses are generated.

Reset
REQ-028 While aresetn=0, the FSM SHALL be in IDLE, with awready, wready, arready, bvalid, rvalid, ip_en and ip_wen all 0.
REQ-029 While aresetn=0, bresp, rresp, rdata, ip_addr and ip_wdata SHALL be 0.
REQ-030 Reset assertion mid-transaction SHALL abort it immediately, with no response issued.
REQ-031 After aresetn deasserts, SHALL accept handshakes from the first rising edge.

Verification (ADDR_WIDTH=8, IP_DATA_WIDTH=8)
REQ-032 Write awaddr=0x14, wdata=0x1234_56A5 -> 1 cycle later ip_en=1, ip_wen=1, ip_addr=0x05, ip_wdata=0xA5 for one cycle; then bvalid=1, bresp=0.
REQ-033 Read araddr=0x16, IP returns ip_rack with ip_rdata=0xC3 three cycles after ip_en (ip_addr=0x05, ip_wen=0) -> rvalid=1, rdata=0x0000_00C3, rresp=0.
REQ-034 awvalid, wvalid and arvalid all high in the same IDLE cycle -> write completes first (arready=0); read is accepted the cycle after bready handshake.
REQ-035 awvalid=1 with wvalid=0 for 5 cycles -> awready stays 0 and no ip_en; raising wvalid -> handshake in that cycle.
REQ-036 bready held 0 for 4 cycles -> bvalid stays 1, arready stays 0; same holds for rvalid with rready=0, and rdata stays stable.
REQ-037 aresetn pulsed low during RD_WAIT -> outputs go to reset values at once; a later ip_rack produces no rvalid.
